// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, load/store and memory-side signals of the shared memory port arbiter.
// Parameters: AW address width, DW data width (multiple of 8).
// Ports: master = requesters and memory (the environment); slave = the arbiter.
//   Fetch:  i_req, i_addr, i_flush -> ; <- i_done, i_rdata, stall_i
//   Data:   d_req, d_we, d_addr, d_wdata, d_be -> ; <- d_done, d_rdata, stall_d
//   Memory: <- mem_req, mem_we, mem_addr, mem_wdata, mem_be ; mem_ack, mem_rdata ->
//   owner:  00 idle, 01 fetch, 10 data
interface mem_port_arbiter_if #(parameter int AW = 32, parameter int DW = 32);
  logic            i_req;
  logic [AW-1:0]   i_addr;
  logic            i_flush;
  logic            i_done;
  logic [DW-1:0]   i_rdata;
  logic            d_req;
  logic            d_we;
  logic [AW-1:0]   d_addr;
  logic [DW-1:0]   d_wdata;
  logic [DW/8-1:0] d_be;
  logic            d_done;
  logic [DW-1:0]   d_rdata;
  logic            mem_req;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW/8-1:0] mem_be;
  logic            mem_ack;
  logic [DW-1:0]   mem_rdata;
  logic            stall_i;
  logic            stall_d;
  logic [1:0]      owner;
  modport master (
    output i_req, i_addr, i_flush, d_req, d_we, d_addr, d_wdata, d_be, mem_ack, mem_rdata,
    input  i_done, i_rdata, d_done, d_rdata, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
           stall_i, stall_d, owner
  );
  modport slave (
    input  i_req, i_addr, i_flush, d_req, d_we, d_addr, d_wdata, d_be, mem_ack, mem_rdata,
    output i_done, i_rdata, d_done, d_rdata, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
           stall_i, stall_d, owner
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: one-transaction-at-a-time arbiter of the single-port memory between fetch and load/store.
// Ports: clk, rst_n (async active-low); bus (mem_port_arbiter_if.slave) carrying the fetch request,
// data request, memory request/ack, per-requester stalls and the current owner.
module mem_port_arbiter #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int MAX_D_BURST = 4
) (
  input logic              clk,
  input logic              rst_n,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'b00, BUSY_I = 2'b01, BUSY_D = 2'b10} state_t;
  localparam logic [3:0] MAX = 4'(MAX_D_BURST);
  state_t     state;
  logic [3:0] streak;
  logic       drop;
  logic       i_ok;
  logic       grant_d;
  logic       grant_i;
  assign i_ok    = bus.i_req & ~bus.i_flush;
  // Data wins unless a live fetch has already waited out MAX_D_BURST data grants.
  assign grant_d = (state == IDLE) & bus.d_req & ~(i_ok & (streak == MAX));
  assign grant_i = (state == IDLE) & ~grant_d & i_ok;
  // A flush in the ack cycle itself cancels the fetch just like an earlier one.
  assign bus.i_done  = bus.mem_ack & (bus.owner == 2'b01) & ~drop & ~bus.i_flush;
  assign bus.d_done  = bus.mem_ack & (bus.owner == 2'b10);
  assign bus.i_rdata = bus.mem_rdata;
  assign bus.d_rdata = bus.mem_rdata;
  assign bus.stall_i = bus.i_req & ~bus.i_done;
  assign bus.stall_d = bus.d_req & ~bus.d_done;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      bus.owner     <= 2'b00;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= {AW{1'b0}};
      bus.mem_wdata <= {DW{1'b0}};
      bus.mem_be    <= {(DW/8){1'b0}};
      streak        <= 4'd0;
      drop          <= 1'b0;
    end else if (grant_d) begin
      state         <= BUSY_D;
      bus.owner     <= 2'b10;
      bus.mem_req   <= 1'b1;
      bus.mem_we    <= bus.d_we;
      bus.mem_addr  <= bus.d_addr;
      bus.mem_wdata <= bus.d_wdata;
      bus.mem_be    <= bus.d_be;
      // A flushed-but-present i_req neither counts as waiting nor as absent.
      streak        <= i_ok ? ((streak == MAX) ? MAX : streak + 4'd1) : bus.i_req ? streak : 4'd0;
    end else if (grant_i) begin
      state         <= BUSY_I;
      bus.owner     <= 2'b01;
      bus.mem_req   <= 1'b1;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= bus.i_addr;
      bus.mem_wdata <= {DW{1'b0}};
      bus.mem_be    <= {(DW/8){1'b1}};
      streak        <= 4'd0;
    end else if (state != IDLE && bus.mem_ack) begin
      state       <= IDLE;
      bus.owner   <= 2'b00;
      bus.mem_req <= 1'b0;
      drop        <= 1'b0;
    end else if (state == BUSY_I && bus.i_flush) begin
      drop <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus a randomized run against a transaction-level reference model.
module tb_mem_port_arbiter;
  localparam int AW = 32, DW = 32, MAXB = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] mmem [logic [31:0]];
  logic [31:0] rmem [logic [31:0]];
  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus();
  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_D_BURST(MAXB)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction
  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] w, input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = w[8*b +: 8];
    return r;
  endfunction
  function automatic logic [31:0] rref(input logic [31:0] a);
    return rmem.exists(a) ? rmem[a] : dflt(a);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
    bus.mem_ack = 1'b0;
  endtask
  task automatic smp;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) smp;
    n_cmp++;
    if ({bus.mem_req, bus.mem_we, bus.owner} !== 4'b0) begin
      n_err++; $display("FAIL reset_ctrl: got %b want 0000", {bus.mem_req, bus.mem_we, bus.owner});
    end
    n_cmp++;
    if ({bus.mem_addr, bus.mem_wdata, bus.mem_be} !== 68'h0) begin
      n_err++; $display("FAIL reset_fields: got %h want 0", {bus.mem_addr, bus.mem_wdata, bus.mem_be});
    end
    n_cmp++;
    if ({bus.i_done, bus.d_done, bus.stall_i, bus.stall_d} !== 4'b0) begin
      n_err++; $display("FAIL reset_comb: got %b want 0000", {bus.i_done, bus.d_done, bus.stall_i, bus.stall_d});
    end
    tick;
    rst_n = 1'b1;
  endtask

  task automatic test_fetch;
    tick;
    bus.i_req = 1'b1; bus.i_addr = 32'h100;
    smp;
    n_cmp++;
    if ({bus.mem_req, bus.stall_i} !== 2'b01) begin
      n_err++; $display("FAIL fetch_pre: got req/stall %b want 01", {bus.mem_req, bus.stall_i});
    end
    tick; smp;
    n_cmp++;
    if ({bus.owner, bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr} !== {2'b01, 1'b1, 1'b0, 4'hF, 32'h100}) begin
      n_err++; $display("FAIL fetch_grant: got %h want %h", {bus.owner, bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr},
                        {2'b01, 1'b1, 1'b0, 4'hF, 32'h100});
    end
    tick; smp;
    n_cmp++;
    if (bus.i_done !== 1'b0) begin
      n_err++; $display("FAIL fetch_early_done: got %b want 0", bus.i_done);
    end
    tick;
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1234_5678;
    smp;
    n_cmp++;
    if ({bus.i_done, bus.d_done, bus.stall_i, bus.i_rdata} !== {3'b100, 32'h1234_5678}) begin
      n_err++; $display("FAIL fetch_done: got %h want %h", {bus.i_done, bus.d_done, bus.stall_i, bus.i_rdata}, {3'b100, 32'h1234_5678});
    end
    tick;
    bus.i_req = 1'b0;
    smp;
    n_cmp++;
    if ({bus.owner, bus.mem_req, bus.i_done, bus.stall_i} !== 5'b0) begin
      n_err++; $display("FAIL fetch_after: got %b want 00000", {bus.owner, bus.mem_req, bus.i_done, bus.stall_i});
    end
  endtask

  task automatic test_priority;
    tick;
    bus.i_req = 1'b1; bus.i_addr = 32'h200;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h40; bus.d_wdata = 32'hDEAD_BEEF; bus.d_be = 4'h3;
    tick; smp;
    n_cmp++;
    if ({bus.owner, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata} !== {2'b10, 1'b1, 4'h3, 32'h40, 32'hDEAD_BEEF}) begin
      n_err++; $display("FAIL prio_data_first: got %h want %h", {bus.owner, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata},
                        {2'b10, 1'b1, 4'h3, 32'h40, 32'hDEAD_BEEF});
    end
    tick;
    bus.mem_ack = 1'b1;
    smp;
    n_cmp++;
    if ({bus.d_done, bus.i_done, bus.stall_i} !== 3'b101) begin
      n_err++; $display("FAIL prio_d_done: got %b want 101", {bus.d_done, bus.i_done, bus.stall_i});
    end
    tick;
    bus.d_req = 1'b0;
    smp;
    n_cmp++;
    if ({bus.owner, bus.mem_req} !== 3'b0) begin
      n_err++; $display("FAIL prio_idle_gap: got %b want 000", {bus.owner, bus.mem_req});
    end
    tick; smp;
    n_cmp++;
    if ({bus.owner, bus.mem_addr} !== {2'b01, 32'h200}) begin
      n_err++; $display("FAIL prio_fetch_next: got %h want %h", {bus.owner, bus.mem_addr}, {2'b01, 32'h200});
    end
    tick;
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0BAD_F00D;
    smp;
    n_cmp++;
    if ({bus.i_done, bus.i_rdata} !== {1'b1, 32'h0BAD_F00D}) begin
      n_err++; $display("FAIL prio_i_done: got %h want %h", {bus.i_done, bus.i_rdata}, {1'b1, 32'h0BAD_F00D});
    end
    tick;
    bus.i_req = 1'b0;
  endtask

  task automatic test_starvation;
    logic [1:0] exp_o [6] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10};
    tick;
    bus.i_req = 1'b1; bus.i_addr = 32'h300;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h80;
    for (int k = 0; k < 6; k++) begin
      int w;
      w = 0;
      do begin tick; smp; w++; end while (!bus.mem_req && w < 4);
      n_cmp++;
      if (bus.owner !== exp_o[k]) begin
        n_err++; $display("FAIL starve_grant%0d: got owner %b want %b", k, bus.owner, exp_o[k]);
      end
      tick;
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'(k);
      smp;
      n_cmp++;
      if ({bus.i_done, bus.d_done} !== ((exp_o[k] == 2'b01) ? 2'b10 : 2'b01)) begin
        n_err++; $display("FAIL starve_done%0d: got %b want %b", k, {bus.i_done, bus.d_done}, (exp_o[k] == 2'b01) ? 2'b10 : 2'b01);
      end
    end
    tick;
    bus.i_req = 1'b0; bus.d_req = 1'b0;
  endtask

  task automatic test_flush_busy;
    tick;
    bus.i_req = 1'b1; bus.i_addr = 32'h400;
    tick; smp;
    n_cmp++;
    if (bus.owner !== 2'b01) begin
      n_err++; $display("FAIL flushb_grant: got %b want 01", bus.owner);
    end
    tick;
    bus.i_flush = 1'b1;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h90;
    tick;
    bus.i_flush = 1'b0; bus.i_req = 1'b0;
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hCAFE;
    smp;
    n_cmp++;
    if ({bus.i_done, bus.d_done} !== 2'b00) begin
      n_err++; $display("FAIL flushb_no_done: got %b want 00", {bus.i_done, bus.d_done});
    end
    tick; smp;
    n_cmp++;
    if ({bus.owner, bus.mem_req} !== 3'b0) begin
      n_err++; $display("FAIL flushb_idle: got %b want 000", {bus.owner, bus.mem_req});
    end
    tick; smp;
    n_cmp++;
    if ({bus.owner, bus.mem_addr} !== {2'b10, 32'h90}) begin
      n_err++; $display("FAIL flushb_data: got %h want %h", {bus.owner, bus.mem_addr}, {2'b10, 32'h90});
    end
    tick;
    bus.mem_ack = 1'b1;
    smp;
    n_cmp++;
    if (bus.d_done !== 1'b1) begin
      n_err++; $display("FAIL flushb_d_done: got %b want 1", bus.d_done);
    end
    tick;
    bus.d_req = 1'b0;
  endtask

  task automatic test_flush_idle;
    tick;
    bus.i_req = 1'b1; bus.i_addr = 32'h500; bus.i_flush = 1'b1;
    tick;
    bus.i_flush = 1'b0;
    smp;
    n_cmp++;
    if ({bus.mem_req, bus.owner} !== 3'b0) begin
      n_err++; $display("FAIL flushi_blocked: got %b want 000", {bus.mem_req, bus.owner});
    end
    tick; smp;
    n_cmp++;
    if (bus.owner !== 2'b01) begin
      n_err++; $display("FAIL flushi_grant: got %b want 01", bus.owner);
    end
    tick;
    bus.mem_ack = 1'b1; bus.i_flush = 1'b1;
    smp;
    n_cmp++;
    if (bus.i_done !== 1'b0) begin
      n_err++; $display("FAIL flushi_ack_cycle: got %b want 0", bus.i_done);
    end
    tick;
    bus.i_flush = 1'b0; bus.i_req = 1'b0;
    smp;
    n_cmp++;
    if ({bus.mem_req, bus.owner} !== 3'b0) begin
      n_err++; $display("FAIL flushi_end: got %b want 000", {bus.mem_req, bus.owner});
    end
  endtask

  task automatic test_reset_mid;
    tick;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h50; bus.d_wdata = 32'h11; bus.d_be = 4'hF;
    tick; smp;
    n_cmp++;
    if (bus.owner !== 2'b10) begin
      n_err++; $display("FAIL rstmid_grant: got %b want 10", bus.owner);
    end
    #1;
    bus.mem_ack = 1'b1; rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.mem_req, bus.owner, bus.d_done, bus.mem_addr} !== 36'h0) begin
      n_err++; $display("FAIL rstmid_clear: got %h want 0", {bus.mem_req, bus.owner, bus.d_done, bus.mem_addr});
    end
    tick;
    tick;
    rst_n = 1'b1;
    bus.d_we = 1'b0; bus.d_addr = 32'h60;
    tick; smp;
    n_cmp++;
    if ({bus.owner, bus.mem_addr} !== {2'b10, 32'h60}) begin
      n_err++; $display("FAIL rstmid_resume: got %h want %h", {bus.owner, bus.mem_addr}, {2'b10, 32'h60});
    end
    tick;
    bus.mem_ack = 1'b1;
    smp;
    n_cmp++;
    if (bus.d_done !== 1'b1) begin
      n_err++; $display("FAIL rstmid_d_done: got %b want 1", bus.d_done);
    end
    tick;
    bus.d_req = 1'b0;
  endtask

  task automatic test_random;
    int streak_m, cnt, lat;
    logic [1:0] m_owner;
    logic m_drop, p_iok, p_ireq, p_d, p_ack, l_idone, l_ddone, exp_i, exp_d;
    logic [31:0] a, old;
    streak_m = 0; cnt = 0; lat = 1; m_owner = 2'b00; m_drop = 1'b0;
    p_iok = 1'b0; p_ireq = 1'b0; p_d = 1'b0; p_ack = 1'b0; l_idone = 1'b0; l_ddone = 1'b0;
    tick;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      tick;
      bus.i_flush = 1'b0;
      if (bus.i_req && l_idone) bus.i_req = 1'b0;
      if (bus.d_req && l_ddone) bus.d_req = 1'b0;
      if (bus.i_req && $urandom_range(0, 19) == 0) begin
        bus.i_flush = 1'b1; bus.i_req = 1'b0;
      end else if (!bus.i_req && $urandom_range(0, 2) == 0) begin
        bus.i_req = 1'b1; bus.i_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      end
      if (!bus.d_req && $urandom_range(0, 1) == 0) begin
        bus.d_req = 1'b1; bus.d_we = 1'($urandom_range(0, 1));
        bus.d_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
        bus.d_wdata = $urandom; bus.d_be = 4'($urandom_range(1, 15));
      end
      if (bus.mem_req) begin
        cnt++;
        if (cnt > lat) begin
          a = bus.mem_addr;
          old = mmem.exists(a) ? mmem[a] : dflt(a);
          bus.mem_ack = 1'b1; bus.mem_rdata = old;
          if (bus.mem_we) mmem[a] = merge(old, bus.mem_wdata, bus.mem_be);
          cnt = 0; lat = $urandom_range(1, 3);
        end
      end else cnt = 0;
      smp;
      if (m_owner == 2'b00) begin
        if (p_d && !(p_iok && streak_m == MAXB)) begin
          m_owner = 2'b10;
          streak_m = p_iok ? ((streak_m + 1 > MAXB) ? MAXB : streak_m + 1) : (p_ireq ? streak_m : 0);
        end else if (p_iok) begin
          m_owner = 2'b01; streak_m = 0;
        end
      end else if (p_ack) m_owner = 2'b00;
      n_cmp++;
      if (bus.owner !== m_owner) begin
        n_err++; $display("FAIL rnd_owner c%0d: got %b want %b", c, bus.owner, m_owner);
      end
      exp_i = bus.mem_ack & (m_owner == 2'b01) & ~m_drop & ~bus.i_flush;
      exp_d = bus.mem_ack & (m_owner == 2'b10);
      n_cmp++;
      if ({bus.i_done, bus.d_done} !== {exp_i, exp_d}) begin
        n_err++; $display("FAIL rnd_done c%0d: got %b want %b", c, {bus.i_done, bus.d_done}, {exp_i, exp_d});
      end
      if (bus.d_done) begin
        n_cmp++;
        if ({bus.mem_we, bus.mem_addr} !== {bus.d_we, bus.d_addr}) begin
          n_err++; $display("FAIL rnd_d_addr c%0d: got %h want %h", c, {bus.mem_we, bus.mem_addr}, {bus.d_we, bus.d_addr});
        end
        if (bus.d_we) rmem[bus.d_addr] = merge(rref(bus.d_addr), bus.d_wdata, bus.d_be);
        else begin
          n_cmp++;
          if (bus.d_rdata !== rref(bus.d_addr)) begin
            n_err++; $display("FAIL rnd_load c%0d: got %h want %h", c, bus.d_rdata, rref(bus.d_addr));
          end
        end
      end
      if (bus.i_done) begin
        n_cmp++;
        if ({bus.i_req, bus.i_rdata} !== {1'b1, rref(bus.i_addr)}) begin
          n_err++; $display("FAIL rnd_fetch c%0d: got %h want %h", c, {bus.i_req, bus.i_rdata}, {1'b1, rref(bus.i_addr)});
        end
      end
      if (bus.mem_ack) m_drop = 1'b0;
      else if (m_owner == 2'b01 && bus.i_flush) m_drop = 1'b1;
      p_iok = bus.i_req & ~bus.i_flush; p_ireq = bus.i_req; p_d = bus.d_req; p_ack = bus.mem_ack;
      l_idone = bus.i_done; l_ddone = bus.d_done;
    end
    tick;
    bus.i_req = 1'b0; bus.d_req = 1'b0; bus.i_flush = 1'b0;
  endtask

  initial begin
    bus.i_req = 1'b0; bus.i_addr = '0; bus.i_flush = 1'b0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_be = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    test_reset;
    test_fetch;
    test_priority;
    test_starvation;
    test_flush_busy;
    test_flush_idle;
    test_reset_mid;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single-port instruction/data memory between the fetch unit (IFU) and the execute-stage load/store path of the 5-stage F/D/R/E/W pipeline. Holds one memory transaction at a time. Data accesses take priority, and a starvation guard ensures fetch still makes progress. Produces per-requester stall signals that the pipeline hazard controller ORs into its IFU and E-stage freeze logic. Cancels in-flight fetches when a branch flushes the front end.

## Interface
- AW, 32, address width.
- DW, 32, data width; must be a multiple of 8.
- MAX_D_BURST, 4, maximum consecutive data grants while fetch is waiting; range 1–15.

- clk  in  1  clock; rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_req  in  1  fetch request; held until i_done or i_flush.
- i_addr  in  AW  fetch address; stable while i_req.
- i_flush  in  1  fetch cancel; driven by flush_IFU.
- i_done  out  1  one-cycle pulse; i_rdata valid.
- i_rdata  out  DW  fetched word.
- d_req  in  1  data request; held until d_done.
- d_we  in  1  1 = store.
- d_addr  in  AW  data address.
- d_wdata  in  DW  store data.
- d_be  in  DW/8  byte enables.
- d_done  out  1  one-cycle completion pulse.
- d_rdata  out  DW  load data.
- mem_req  out  1  memory request; registered.
- mem_we  out  1  write enable; registered.
- mem_addr  out  AW  registered.
- mem_wdata  out  DW  registered.
- mem_be  out  DW/8  registered; all ones for fetch.
- mem_ack  in  1  one-cycle completion from memory; any latency ≥1 cycle after mem_req rises.
- mem_rdata  in  DW  valid with mem_ack.
- stall_i  out  1  i_req & ~i_done; combinational.
- stall_d  out  1  d_req & ~d_done; combinational.
- owner  out  2  00 idle, 01 fetch, 10 data; registered.

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE:
  - If d_req and not (i_req & ~i_flush & streak == MAX_D_BURST): go to BUSY_D.
  - Else if i_req & ~i_flush: go to BUSY_I.
  - Else stay in IDLE.
- On entry to BUSY_*: latch mem_req = 1 and the mem_* fields from the winning requester.
- BUSY_*: mem_req and all mem_* fields stay constant until mem_ack. On mem_ack, go to IDLE and clear mem_req. mem_ack in IDLE is ignored.
- i_done = mem_ack & (owner == 01) & ~drop.
- d_done = mem_ack & (owner == 10).
- rdata outputs pass mem_rdata through combinationally.
- drop flag: set by i_flush while in BUSY_I; cleared on entry to IDLE. When set, the fetch ack is consumed silently and no i_done pulses. i_flush in the same cycle as the fetch mem_ack also suppresses i_done.
- i_flush in IDLE blocks a fetch grant that cycle. Data requests are unaffected.
- streak counter (4 bits):
  - Increments on each data grant made while i_req & ~i_flush.
  - Clears on a fetch grant, or on a data grant made with i_req low.
  - Saturates at MAX_D_BURST.
- Simultaneous d_req and i_req with streak < MAX_D_BURST: data wins.

## Timing
- Reset values: FSM IDLE, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, mem_be 0, owner 00, streak 0, drop 0. Combinational outputs follow, so i_done, d_done, stall_* are 0 with requests low.
- Grant latency: a request sampled at rising edge N drives mem_req high after edge N.
- Completion: mem_ack in cycle M gives the done pulse in the same cycle M, and the FSM is IDLE after edge M.
- Back-to-back: a new grant can occur at edge M+1 at the earliest, so there is at least one idle cycle between transactions.
- Minimum transaction (ack in the cycle after mem_req rises): 2 cycles from request to done.
- Reset asserted mid-transaction: everything returns to reset values immediately. Requester and memory share rst_n, so there is no outstanding-ack recovery.

## Test plan
- Fetch only: i_req, addr 0x100; mem_ack 2 cycles after mem_req. Required: mem_req rises 1 cycle after i_req; mem_be = 0xF; i_done pulses with i_rdata = mem_rdata; stall_i low after the done cycle.
- Both requests in the same cycle, idle arbiter. Required: data (store 0xDEADBEEF, be 0x3) granted first and mem_we = 1. After d_done, one idle cycle, then fetch granted.
- Starvation, MAX_D_BURST = 4: d_req held continuously with i_req high. Required: exactly 4 data transactions, then a fetch grant, then data resumes.
- Flush during fetch: i_flush pulsed in BUSY_I. Required: no i_done on mem_ack; owner returns to 00; a pending d_req is granted at the next edge.
- Flush in IDLE with i_req high and d_req low. Required: no grant that cycle; mem_req stays 0.
- Reset mid-transaction: rst_n low while in BUSY_D. Required: mem_req and owner are 0 immediately; no d_done; normal operation resumes after reset is released.
